// File: rtl/lsu_align_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_ctrl_if
// Description : MEM-stage request/response bundle between the pipeline and
//               the load/store alignment controller.
//               master : pipeline side (drives the request, sees the
//                        stall / load result / illegal pulse)
//               slave  : alignment controller side
//               Signals:
//                 req_valid   request present this cycle
//                 req_we      1 = store, 0 = load
//                 req_funct3  access type (lb/lh/lw/lbu/lhu, sb/sh/sw)
//                 req_addr    byte address
//                 req_wdata   store data (rs2)
//                 stall       hold the pipeline this cycle
//                 load_data   extended load result (registered)
//                 load_valid  one-cycle pulse, load_data valid
//                 illegal     one-cycle pulse, unsupported funct3
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_align_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        illegal;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  stall, load_data, load_valid, illegal
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output stall, load_data, load_valid, illegal
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_ctrl
// Description : Load/store alignment controller sitting between the MEM
//               stage and a word-organised data memory. Converts byte
//               address requests into word accesses with byte enables,
//               lane-aligns store data and extracts/extends load data.
//               An access that crosses a word boundary is split into two
//               consecutive memory accesses with a one-cycle stall.
//               Optional build macro:
//                 LSU_MISALIGN_TRAP_EN - word-crossing requests are not
//                   split; they perform no access and raise a registered
//                   misalign_exc pulse instead.
//               Ports:
//                 clk        rising-edge clock
//                 reset      asynchronous, active-low reset
//                 bus        request/response bundle (slave modport)
//                 mem_cs     memory chip select, active-low
//                 mem_rd     1 = read, 0 = write
//                 mem_addr   word index (WORD_AW bits)
//                 mem_mask   byte enables, bit i = lane i
//                 mem_wdata  lane-aligned write data
//                 mem_rdata  raw read word, same-cycle combinational
//                 misalign_exc (trap build only) misaligned-access pulse
//               WORD_AW must not exceed 30.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_ctrl #(
  parameter int WORD_AW = 30
) (
  input  logic               clk,
  input  logic               reset,
  lsu_align_ctrl_if.slave    bus,
  output logic               mem_cs,
  output logic               mem_rd,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [3:0]         mem_mask,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic               misalign_exc
`endif
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  // Byte-enable pattern of an access at offset 0 for a given size code.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Keep the low 1/2/4 bytes; funct3[2] selects zero extension.
  function automatic logic [31:0] extend(input logic [2:0] f3,
                                         input logic [31:0] raw);
    case (f3[1:0])
      2'b00:   extend = {{24{raw[7]  & ~f3[2]}}, raw[7:0]};
      2'b01:   extend = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  // Request latched at the first half of a split access.
  logic [WORD_AW-1:0] r_word;
  logic [1:0]         r_off;
  logic [2:0]         r_funct3;
  logic               r_we;
  logic [3:0]         r_mask_hi;
  logic [31:0]        r_wdata_hi;
  logic [31:0]        r_hold;

  logic [31:0]        r_load_data;
  logic               r_load_valid;
  logic               r_illegal;

  // Live-request decode.
  logic [1:0]         w_off;
  logic [7:0]         w_bm8;
  logic [63:0]        w_wsh;
  logic               w_split;
  logic               w_legal;
  logic [WORD_AW-1:0] w_word;

  // FSM outputs / control.
  logic               w_latch;
  logic               w_ld_done;
  logic               w_ld_split;
  logic               w_illegal_nxt;

  // Load assembly.
  logic [1:0]         w_sel_off;
  logic [2:0]         w_sel_funct3;
  logic [63:0]        w_cat;
  logic [31:0]        w_raw;

  assign w_off   = bus.req_addr[1:0];
  assign w_bm8   = {4'b0000, size_mask(bus.req_funct3[1:0])} << w_off;
  assign w_wsh   = {32'h0000_0000, bus.req_wdata} << {w_off, 3'b000};
  assign w_split = |w_bm8[7:4];
  assign w_word  = bus.req_addr[WORD_AW+1:2];

  always_comb begin
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~bus.req_we;
      default:                w_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign_nxt;
`endif

  // Next state and memory-side outputs. Everything is forced idle while
  // reset is asserted so the memory sees no access even if a request is
  // presented during reset.
  always_comb begin
    w_state_nxt   = r_state;
    mem_cs        = 1'b1;
    mem_rd        = 1'b1;
    mem_addr      = '0;
    mem_mask      = 4'b0000;
    mem_wdata     = 32'h0000_0000;
    bus.stall     = 1'b0;
    w_latch       = 1'b0;
    w_ld_done     = 1'b0;
    w_ld_split    = 1'b0;
    w_illegal_nxt = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign_nxt = 1'b0;
`endif
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (!w_legal) begin
              w_illegal_nxt = 1'b1;
            end else if (w_split) begin
`ifdef LSU_MISALIGN_TRAP_EN
              w_misalign_nxt = 1'b1;
`else
              // First half: low lanes of word A, then finish in SECOND.
              mem_cs      = 1'b0;
              mem_rd      = ~bus.req_we;
              mem_addr    = w_word;
              mem_mask    = w_bm8[3:0];
              mem_wdata   = w_wsh[31:0];
              bus.stall   = 1'b1;
              w_latch     = 1'b1;
              w_state_nxt = S_SECOND;
`endif
            end else begin
              mem_cs    = 1'b0;
              mem_rd    = ~bus.req_we;
              mem_addr  = w_word;
              mem_mask  = w_bm8[3:0];
              mem_wdata = w_wsh[31:0];
              w_ld_done = ~bus.req_we;
            end
          end
        end
        S_SECOND: begin
          // Second half from the latched request; live req_* is ignored.
          mem_cs      = 1'b0;
          mem_rd      = ~r_we;
          mem_addr    = r_word + 1'b1;
          mem_mask    = r_mask_hi;
          mem_wdata   = r_wdata_hi;
          w_ld_done   = ~r_we;
          w_ld_split  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // In SECOND the offset/type come from the latched request, and the
  // first word (hold) supplies the low half of the 64-bit window.
  assign w_sel_off    = w_ld_split ? r_off    : w_off;
  assign w_sel_funct3 = w_ld_split ? r_funct3 : bus.req_funct3;
  assign w_cat        = w_ld_split ? {mem_rdata, r_hold}
                                   : {32'h0000_0000, mem_rdata};
  assign w_raw        = 32'(w_cat >> {w_sel_off, 3'b000});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_off        <= 2'b00;
      r_funct3     <= 3'b000;
      r_we         <= 1'b0;
      r_mask_hi    <= 4'b0000;
      r_wdata_hi   <= 32'h0000_0000;
      r_hold       <= 32'h0000_0000;
      r_load_data  <= 32'h0000_0000;
      r_load_valid <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_valid <= w_ld_done;
      r_illegal    <= w_illegal_nxt;
      if (w_ld_done) begin
        r_load_data <= extend(w_sel_funct3, w_raw);
      end
      if (w_latch) begin
        r_word     <= w_word;
        r_off      <= w_off;
        r_funct3   <= bus.req_funct3;
        r_we       <= bus.req_we;
        r_mask_hi  <= w_bm8[7:4];
        r_wdata_hi <= w_wsh[63:32];
        if (!bus.req_we) begin
          r_hold <= mem_rdata;
        end
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
    end
  end
  assign misalign_exc = r_misalign;
`endif

  assign bus.load_data  = r_load_data;
  assign bus.load_valid = r_load_valid;
  assign bus.illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_align_ctrl
// Description : Directed self-checking bench for lsu_align_ctrl. Inputs
//               change 1 ns after the rising edge; combinational outputs
//               are checked 1 ns later, registered outputs 1 ns after the
//               following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_align_ctrl;
  logic        clk;
  logic        reset;
  logic        mem_cs;
  logic        mem_rd;
  logic [29:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int tests;
  int fails;

  lsu_align_ctrl_if bus ();

  lsu_align_ctrl #(.WORD_AW(30)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_mask  (mem_mask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_exc (misalign_exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    mem_rdata = 32'h0;
    // A live request during reset must not reach the memory.
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    repeat (2) tick();
    #1;
    chk("rst_cs",    32'(mem_cs), 32'h1);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_lv",    32'(bus.load_valid), 32'h0);
    chk("rst_ld",    bus.load_data, 32'h0);
    chk("rst_ill",   32'(bus.illegal), 32'h0);

    // Aligned sw
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    #1;
    chk("sw_cs",    32'(mem_cs), 32'h0);
    chk("sw_rd",    32'(mem_rd), 32'h0);
    chk("sw_addr",  32'(mem_addr), 32'h4);
    chk("sw_mask",  32'(mem_mask), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(bus.stall), 32'h0);

    // sb to lane 3
    tick();
    chk("sw_no_lv", 32'(bus.load_valid), 32'h0);
    drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h000000A5);
    #1;
    chk("sb_mask",  32'(mem_mask), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5000000);
    chk("sb_addr",  32'(mem_addr), 32'h4);

    // lb from lane 3 (sign-extended)
    tick();
    drive(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
    mem_rdata = 32'hA5000000;
    #1;
    chk("lb_rd",   32'(mem_rd), 32'h1);
    chk("lb_mask", 32'(mem_mask), 32'h8);

    // lbu from lane 3
    tick();
    chk("lb_lv", 32'(bus.load_valid), 32'h1);
    chk("lb_ld", bus.load_data, 32'hFFFFFFA5);
    drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    #1;

    // lh / lhu at offset 1 (misaligned but within one word)
    tick();
    chk("lbu_lv", 32'(bus.load_valid), 32'h1);
    chk("lbu_ld", bus.load_data, 32'h000000A5);
    drive(1'b1, 1'b0, 3'b001, 32'h0D, 32'h0);
    mem_rdata = 32'h00807F00;
    #1;
    chk("lh1_addr",  32'(mem_addr), 32'h3);
    chk("lh1_mask",  32'(mem_mask), 32'h6);
    chk("lh1_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("lh1_ld", bus.load_data, 32'hFFFF807F);
    drive(1'b1, 1'b0, 3'b101, 32'h0D, 32'h0);
    mem_rdata = 32'h00BEEF00;
    #1;
    tick();
    chk("lhu1_ld", bus.load_data, 32'h0000BEEF);

    // Illegal load funct3=011, then illegal store funct3=100
    drive(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
    #1;
    chk("ill_ld_cs",   32'(mem_cs), 32'h1);
    chk("ill_ld_mask", 32'(mem_mask), 32'h0);
    tick();
    chk("ill_ld_pulse", 32'(bus.illegal), 32'h1);
    chk("ill_ld_nolv",  32'(bus.load_valid), 32'h0);
    drive(1'b1, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF);
    #1;
    chk("ill_st_cs",    32'(mem_cs), 32'h1);
    chk("ill_st_wdata", mem_wdata, 32'h0);
    tick();
    chk("ill_st_pulse", 32'(bus.illegal), 32'h1);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    chk("idle_cs", 32'(mem_cs), 32'h1);
    chk("idle_rd", 32'(mem_rd), 32'h1);
    tick();
    chk("ill_clear", 32'(bus.illegal), 32'h0);

`ifndef LSU_MISALIGN_TRAP_EN
    // Split lw at 0x0E
    drive(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
    mem_rdata = 32'hBBAA0000;
    #1;
    chk("slw0_addr",  32'(mem_addr), 32'h3);
    chk("slw0_mask",  32'(mem_mask), 32'hC);
    chk("slw0_stall", 32'(bus.stall), 32'h1);
    chk("slw0_cs",    32'(mem_cs), 32'h0);
    tick();
    chk("slw0_nolv", 32'(bus.load_valid), 32'h0);
    // Live request must be ignored during the second half.
    drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h55555555);
    mem_rdata = 32'h0000DDCC;
    #1;
    chk("slw1_addr",  32'(mem_addr), 32'h4);
    chk("slw1_mask",  32'(mem_mask), 32'h3);
    chk("slw1_stall", 32'(bus.stall), 32'h0);
    chk("slw1_rd",    32'(mem_rd), 32'h1);
    tick();
    chk("slw_lv", 32'(bus.load_valid), 32'h1);
    chk("slw_ld", bus.load_data, 32'hDDCCBBAA);

    // Split sh at 0x07
    drive(1'b1, 1'b1, 3'b001, 32'h07, 32'h00001234);
    #1;
    chk("ssh0_addr",  32'(mem_addr), 32'h1);
    chk("ssh0_mask",  32'(mem_mask), 32'h8);
    chk("ssh0_wdata", mem_wdata, 32'h34000000);
    chk("ssh0_stall", 32'(bus.stall), 32'h1);
    tick();
    chk("ssh_ld_hold", bus.load_data, 32'hDDCCBBAA);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("ssh1_addr",  32'(mem_addr), 32'h2);
    chk("ssh1_mask",  32'(mem_mask), 32'h1);
    chk("ssh1_wdata", mem_wdata, 32'h00000012);
    chk("ssh1_rd",    32'(mem_rd), 32'h0);
    tick();
    chk("ssh_nolv", 32'(bus.load_valid), 32'h0);

    // Split lw wrapping the top of the word address space
    drive(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    mem_rdata = 32'h55660000;
    #1;
    chk("wrap0_addr", 32'(mem_addr), 32'h3FFFFFFF);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_rdata = 32'h00007788;
    #1;
    chk("wrap1_addr", 32'(mem_addr), 32'h0);
    chk("wrap1_mask", 32'(mem_mask), 32'h3);
    tick();
    chk("wrap_ld", bus.load_data, 32'h77885566);

    // Reset asserted while in SECOND
    drive(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
    mem_rdata = 32'hBBAA0000;
    #1;
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_rdata = 32'h0000DDCC;
    #1;
    chk("rs2_cs_before", 32'(mem_cs), 32'h0);
    reset = 1'b0;
    #1;
    chk("rs2_cs",    32'(mem_cs), 32'h1);
    chk("rs2_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("rs2_nolv", 32'(bus.load_valid), 32'h0);
    chk("rs2_ld",   bus.load_data, 32'h0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    mem_rdata = 32'h11223344;
    #1;
    chk("post_cs",    32'(mem_cs), 32'h0);
    chk("post_addr",  32'(mem_addr), 32'h4);
    chk("post_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("post_lv", 32'(bus.load_valid), 32'h1);
    chk("post_ld", bus.load_data, 32'h11223344);
`else
    // Word-crossing lw traps instead of splitting
    drive(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
    mem_rdata = 32'hBBAA0000;
    #1;
    chk("trap_cs",    32'(mem_cs), 32'h1);
    chk("trap_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("trap_exc",  32'(misalign_exc), 32'h1);
    chk("trap_nolv", 32'(bus.load_valid), 32'h0);
    drive(1'b1, 1'b0, 3'b001, 32'h0D, 32'h0);
    mem_rdata = 32'h00807F00;
    #1;
    chk("trap_lh_cs",   32'(mem_cs), 32'h0);
    chk("trap_lh_mask", 32'(mem_mask), 32'h6);
    tick();
    chk("trap_lh_noexc", 32'(misalign_exc), 32'h0);
    chk("trap_lh_ld",    bus.load_data, 32'hFFFF807F);
`endif

    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
- Load/store alignment controller in the MEM stage, directly upstream of the word-organised data memory.
- Converts EX/MEM byte-address requests (funct3-typed loads/stores) into word-indexed accesses with byte enables; extracts and sign/zero-extends load data.
- Splits a misaligned access that crosses a word boundary into two consecutive memory accesses, stalling the pipeline for one cycle.

Parameters:
- WORD_AW, 30, width of mem_addr (word index = addr[31:2], truncated to WORD_AW).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage memory request present
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold the pipeline this cycle
- mem_cs  out  1  memory chip select, active-low
- mem_rd  out  1  1 = read, 0 = write
- mem_addr  out  WORD_AW  word index
- mem_mask  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  raw word from memory, same-cycle combinational
- load_data  out  32  extended load result, registered
- load_valid  out  1  one-cycle pulse, load_data valid
- illegal  out  1  one-cycle pulse: unsupported funct3 (011, 110, 111, or 1xx on a store)

Behaviour:
- Size: byte = 1, half = 2, word = 4; off = req_addr[1:0]; bm8 = ((1<<size)-1) << off, an 8-bit mask; split = bm8[7:4] != 0.
- States: IDLE, SECOND.
- IDLE, req_valid, legal, !split:
  - mem_cs = 0; mem_rd = !req_we; mem_addr = req_addr[31:2]; mem_mask = bm8[3:0].
  - mem_wdata = (req_wdata << 8*off)[31:0].
  - stall = 0.
  - Stay in IDLE.
- IDLE, req_valid, legal, split:
  - First access to word A = req_addr[31:2], mask bm8[3:0], wdata = low 32 of ({32'b0, req_wdata} << 8*off).
  - stall = 1.
  - Latch addr, funct3, we, wdata; for loads latch mem_rdata into hold register.
  - Go to SECOND.
- SECOND:
  - Access word A+1, wrapping modulo 2^WORD_AW; mask bm8[7:4]; wdata = high 32 of the shifted value.
  - Uses latched request only; live req_* ignored.
  - stall = 0. Return to IDLE.
- Load assembly:
  - Raw = ({mem_rdata, hold} >> 8*off) for split, else (mem_rdata >> 8*off).
  - Take low size bytes; sign-extend for lb/lh, zero-extend for lbu/lhu.
  - Registered into load_data; load_valid pulses the cycle after the final access. Latency: aligned 1, split 2 cycles from request.
- Idle / illegal cycles:
  - No access on !req_valid or illegal: mem_cs = 1, mem_mask = 0, mem_wdata = 0, mem_rd = 1.
  - illegal pulses registered, the cycle after an illegal req_valid.
- Stores never raise load_valid. load_data holds its value until the next load completes.
- Reset (asynchronous, any time including SECOND):
  - state = IDLE; load_data = 0; load_valid = 0; illegal = 0; hold = 0.
  - Combinational outputs at reset: mem_cs = 1, stall = 0.
  - An interrupted split access is abandoned; its first half stays written if the edge already passed.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
  - Defined: no splitting and SECOND is unused. A split request performs no access (mem_cs = 1) and stall = 0. Output misalign_exc (1 bit, registered) pulses the next cycle. Misaligned requests that do not cross a word (e.g. lh at off = 1) are still serviced.
  - Undefined: misalign_exc is absent; split behaviour as above.

Test Plan:
- Aligned sw: addr 0x10, wdata 0xDEADBEEF -> mem_cs = 0, mem_rd = 0, mem_addr = 4, mask 1111, mem_wdata 0xDEADBEEF, stall = 0.
- sb addr 0x13, wdata 0x000000A5 -> mask 1000, mem_wdata 0xA5000000; then lb 0x13 with mem_rdata 0xA5000000 -> load_data 0xFFFFFFA5 next cycle; lbu -> 0x000000A5.
- Split lw addr 0x0E, word 3 = 0xBBAA0000, word 4 = 0x0000DDCC -> cycle 0: mem_addr 3, mask 1100, stall = 1; cycle 1: mem_addr 4, mask 0011; cycle 2: load_valid, load_data 0xDDCCBBAA.
- Split sh addr 0x07, wdata 0x1234 -> cycle 0: addr 1, mask 1000, wdata 0x34000000; cycle 1: addr 2, mask 0001, wdata 0x00000012.
- Reset asserted during SECOND -> mem_cs = 1 immediately; no load_valid; next request serviced normally from IDLE.
- funct3 = 011 load -> no access (mem_cs = 1), illegal pulses next cycle. With LSU_MISALIGN_TRAP_EN, lw 0x0E -> no access, misalign_exc pulses.
